// File: rtl/painterengine_gpu_blit_walker_if.sv
// Beat stream from the blit walker into the texel fetch/blend path.
// One beat per destination pixel; a beat moves when valid && ready.
interface painterengine_gpu_blit_walker_if #(
    parameter int PARAM_TEXTURE_MAX_SIZE = 16,
    parameter int PARAM_ADDRESS_WIDTH    = 32
);
    logic                              valid;
    logic                              ready;
    logic [PARAM_ADDRESS_WIDTH-1:0]    src_addr;
    logic [PARAM_TEXTURE_MAX_SIZE-1:0] dst_x;
    logic [PARAM_TEXTURE_MAX_SIZE-1:0] dst_y;
    logic                              last;

    modport master (
        output valid,
        output src_addr,
        output dst_x,
        output dst_y,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  src_addr,
        input  dst_x,
        input  dst_y,
        input  last,
        output ready
    );
endinterface

// File: rtl/painterengine_gpu_blit_walker.sv
// Blit walker: takes a clipped source rectangle plus destination origin and
// emits one beat per pixel (source texel byte address + destination x/y),
// honouring the texture mirror mode in the source traversal order.
// The source address is stepped incrementally (+/-4 per column,
// +/-stride*4 per row); the single multiply happens once in SETUP.
module painterengine_gpu_blit_walker #(
    parameter int PARAM_TEXTURE_MAX_SIZE = 16,
    parameter int PARAM_ADDRESS_WIDTH    = 32
) (
    input  logic                              i_wire_clock,
    input  logic                              i_wire_reset,
    input  logic                              i_wire_start,
    input  logic [PARAM_ADDRESS_WIDTH-1:0]    i_wire_texture_base,
    input  logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_texture_width,
    input  logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_x,
    input  logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_y,
    input  logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_clipx,
    input  logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_clipy,
    input  logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_clipw,
    input  logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_cliph,
    input  logic [2:0]                        i_wire_mirror_mode,
    painterengine_gpu_blit_walker_if.master   beat,
    output logic                              o_wire_busy,
    output logic                              o_wire_done
);
    localparam int TW = PARAM_TEXTURE_MAX_SIZE;
    localparam int AW = PARAM_ADDRESS_WIDTH;
    localparam logic [TW-1:0] ONE_TW = TW'(1);
    localparam logic [AW-1:0] ONE_AW = AW'(1);
    localparam logic [AW-1:0] FOUR   = AW'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Command latched at start (p0) and the beat currently presented (p1).
    logic [AW-1:0] base_p0;
    logic [TW-1:0] stride_p0;
    logic [TW-1:0] x_p0;
    logic [TW-1:0] y_p0;
    logic [TW-1:0] clipx_p0;
    logic [TW-1:0] clipy_p0;
    logic [TW-1:0] clipw_p0;
    logic [TW-1:0] cliph_p0;
    logic [2:0]    mode_p0;

    logic [TW-1:0] col_p1;
    logic [TW-1:0] row_p1;
    logic [AW-1:0] row_addr_p1;
    logic [AW-1:0] src_addr_p1;
    logic [TW-1:0] dst_x_p1;
    logic [TW-1:0] dst_y_p1;
    logic          last_p1;

    logic          valid_c;
    logic          busy_c;
    logic          done_c;

    // Byte address of texel (row, col) in a texture with the given pixel stride.
    function automatic logic [AW-1:0] texel_addr(
        input logic [AW-1:0] base,
        input logic [AW-1:0] row,
        input logic [AW-1:0] col,
        input logic [AW-1:0] stride
    );
        return base + ((row * stride + col) << 2);
    endfunction

    logic          mirror_h;
    logic          mirror_v;
    logic          degenerate;
    logic [AW-1:0] col_step;
    logic [AW-1:0] stride_bytes;
    logic [AW-1:0] row_step;
    logic [AW-1:0] first_col;
    logic [AW-1:0] first_row;
    logic [AW-1:0] first_addr;
    logic [TW-1:0] col_next;
    logic [TW-1:0] row_next;
    logic          col_at_end;
    logic          row_at_end;
    logic          fire;

    // Traversal geometry: start texel and per-column / per-row address steps.
    always_comb begin
        mirror_h     = mode_p0[0];
        mirror_v     = mode_p0[1];
        degenerate   = (clipw_p0 == '0) || (cliph_p0 == '0) || mode_p0[2];
        col_step     = mirror_h ? ('0 - FOUR) : FOUR;
        stride_bytes = AW'(stride_p0) << 2;
        row_step     = mirror_v ? ('0 - stride_bytes) : stride_bytes;
        first_col    = AW'(clipx_p0) + (mirror_h ? (AW'(clipw_p0) - ONE_AW) : '0);
        first_row    = AW'(clipy_p0) + (mirror_v ? (AW'(cliph_p0) - ONE_AW) : '0);
        first_addr   = texel_addr(base_p0, first_row, first_col, AW'(stride_p0));
        col_next     = col_p1 + ONE_TW;
        row_next     = row_p1 + ONE_TW;
        col_at_end   = (col_p1 == clipw_p0 - ONE_TW);
        row_at_end   = (row_p1 == cliph_p0 - ONE_TW);
        fire         = (state == ST_EMIT) && beat.ready;
    end

    // State register.
    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        valid_c    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_wire_start) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                busy_c     = 1'b1;
                state_next = degenerate ? ST_DONE : ST_EMIT;
            end
            ST_EMIT: begin
                busy_c  = 1'b1;
                valid_c = 1'b1;
                if (beat.ready && last_p1) state_next = ST_DONE;
            end
            ST_DONE: begin
                done_c = 1'b1;
                if (i_wire_start) state_next = ST_SETUP;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latch, counters and the registered beat.
    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            base_p0     <= '0;
            stride_p0   <= '0;
            x_p0        <= '0;
            y_p0        <= '0;
            clipx_p0    <= '0;
            clipy_p0    <= '0;
            clipw_p0    <= '0;
            cliph_p0    <= '0;
            mode_p0     <= '0;
            col_p1      <= '0;
            row_p1      <= '0;
            row_addr_p1 <= '0;
            src_addr_p1 <= '0;
            dst_x_p1    <= '0;
            dst_y_p1    <= '0;
            last_p1     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    last_p1 <= 1'b0;
                    if (i_wire_start) begin
                        base_p0   <= i_wire_texture_base;
                        stride_p0 <= i_wire_texture_width;
                        x_p0      <= i_wire_x;
                        y_p0      <= i_wire_y;
                        clipx_p0  <= i_wire_clipx;
                        clipy_p0  <= i_wire_clipy;
                        clipw_p0  <= i_wire_clipw;
                        cliph_p0  <= i_wire_cliph;
                        mode_p0   <= i_wire_mirror_mode;
                    end
                end
                ST_SETUP: begin
                    col_p1      <= '0;
                    row_p1      <= '0;
                    row_addr_p1 <= first_addr;
                    src_addr_p1 <= first_addr;
                    dst_x_p1    <= x_p0;
                    dst_y_p1    <= y_p0;
                    last_p1     <= (clipw_p0 == ONE_TW) && (cliph_p0 == ONE_TW);
                end
                ST_EMIT: begin
                    if (fire) begin
                        if (last_p1) begin
                            last_p1 <= 1'b0;
                        end else if (col_at_end) begin
                            col_p1      <= '0;
                            row_p1      <= row_next;
                            row_addr_p1 <= row_addr_p1 + row_step;
                            src_addr_p1 <= row_addr_p1 + row_step;
                            dst_x_p1    <= x_p0;
                            dst_y_p1    <= dst_y_p1 + ONE_TW;
                            last_p1     <= (clipw_p0 == ONE_TW) &&
                                           (row_next == cliph_p0 - ONE_TW);
                        end else begin
                            col_p1      <= col_next;
                            src_addr_p1 <= src_addr_p1 + col_step;
                            dst_x_p1    <= dst_x_p1 + ONE_TW;
                            last_p1     <= (col_next == clipw_p0 - ONE_TW) && row_at_end;
                        end
                    end
                end
                default: begin
                    last_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign beat.valid    = valid_c;
    assign beat.src_addr = src_addr_p1;
    assign beat.dst_x    = dst_x_p1;
    assign beat.dst_y    = dst_y_p1;
    assign beat.last     = last_p1;
    assign o_wire_busy   = busy_c;
    assign o_wire_done   = done_c;
endmodule

// File: tb/tb_painterengine_gpu_blit_walker.sv
// Bench for the blit walker: directed cases from the walk rules plus
// randomized rectangles checked against a formula-level model.
module tb_painterengine_gpu_blit_walker;
    localparam int TW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [TW-1:0] width = '0;
    logic [TW-1:0] x = '0;
    logic [TW-1:0] y = '0;
    logic [TW-1:0] cx = '0;
    logic [TW-1:0] cy = '0;
    logic [TW-1:0] cw = '0;
    logic [TW-1:0] ch = '0;
    logic [2:0]    mode = '0;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] dx;
        logic [15:0] dy;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] obs_addr[$];

    always #5 clk = ~clk;

    painterengine_gpu_blit_walker_if #(
        .PARAM_TEXTURE_MAX_SIZE(TW),
        .PARAM_ADDRESS_WIDTH(AW)
    ) bif ();

    painterengine_gpu_blit_walker #(
        .PARAM_TEXTURE_MAX_SIZE(TW),
        .PARAM_ADDRESS_WIDTH(AW)
    ) dut (
        .i_wire_clock(clk),
        .i_wire_reset(rst),
        .i_wire_start(start),
        .i_wire_texture_base(base),
        .i_wire_texture_width(width),
        .i_wire_x(x),
        .i_wire_y(y),
        .i_wire_clipx(cx),
        .i_wire_clipy(cy),
        .i_wire_clipw(cw),
        .i_wire_cliph(ch),
        .i_wire_mirror_mode(mode),
        .beat(bif),
        .o_wire_busy(busy),
        .o_wire_done(done)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_cmd(input logic [31:0] b, input int w, input int px, input int py,
                           input int qx, input int qy, input int qw, input int qh, input int m);
        base  = b;
        width = 16'(w);
        x     = 16'(px);
        y     = 16'(py);
        cx    = 16'(qx);
        cy    = 16'(qy);
        cw    = 16'(qw);
        ch    = 16'(qh);
        mode  = 3'(m);
    endtask

    // Every beat of the walk, straight from the address/coordinate formulas.
    task automatic build_expected();
        exp_q.delete();
        if (cw != 0 && ch != 0 && mode <= 3) begin
            for (int r = 0; r < int'(ch); r++) begin
                for (int c = 0; c < int'(cw); c++) begin
                    beat_t       b;
                    logic [31:0] sc;
                    logic [31:0] sr;
                    sc = (mode == 1 || mode == 3) ? 32'(int'(cx) + int'(cw) - 1 - c) : 32'(int'(cx) + c);
                    sr = (mode == 2 || mode == 3) ? 32'(int'(cy) + int'(ch) - 1 - r) : 32'(int'(cy) + r);
                    b.addr = base + (sr * 32'(width) + sc) * 32'd4;
                    b.dx   = 16'(int'(x) + c);
                    b.dy   = 16'(int'(y) + r);
                    b.last = (r == int'(ch) - 1) && (c == int'(cw) - 1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // rmode: 0 ready high, 1 random ready, 2 ready low 3 cycles at beat 2.
    task automatic walk(input string tag, input int rmode, input bit poke_start);
        int    k;
        int    first_k;
        int    last_k;
        int    done_k;
        int    xfers;
        int    stalls;
        int    nexp;
        beat_t ob;
        build_expected();
        nexp = exp_q.size();
        obs_addr.delete();
        first_k = -1; last_k = -1; done_k = -1; xfers = 0; stalls = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        check({tag, " setup status"}, {bif.valid, busy, done}, 3'b010);
        while (done_k < 0 && k < 600) begin
            if (poke_start) start = (k == 3);
            case (rmode)
                0:       bif.ready = 1'b1;
                1:       bif.ready = 1'($urandom_range(0, 1));
                default: bif.ready = !(xfers == 1 && stalls < 3);
            endcase
            if (bif.valid) begin
                if (first_k < 0) first_k = k;
                ob = {bif.src_addr, bif.dst_x, bif.dst_y, bif.last};
                if (exp_q.size() != 0) begin
                    check({tag, " beat"}, ob, exp_q[0]);
                    if (bif.ready) exp_q.pop_front();
                end
                if (bif.ready) begin
                    obs_addr.push_back(bif.src_addr);
                    xfers++;
                    last_k = k;
                end else begin
                    stalls++;
                end
            end else if (done) begin
                done_k = k;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        bif.ready = 1'b1;
        check({tag, " done reached"}, done_k >= 0, 1);
        check({tag, " transfers"}, xfers, nexp);
        if (nexp > 0) begin
            check({tag, " first valid latency"}, first_k, 2);
            check({tag, " done after last"}, done_k, last_k + 1);
        end else begin
            check({tag, " degenerate done latency"}, done_k, 2);
        end
        check({tag, " done holds"}, {bif.valid, busy, done}, 3'b001);
    endtask

    initial begin
        bif.ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset state", {bif.valid, busy, done, bif.last, bif.src_addr, bif.dst_x, bif.dst_y}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle status", {bif.valid, busy, done}, 3'b000);

        set_cmd(32'h1000, 8, 10, 20, 2, 1, 3, 2, 0);
        walk("none", 0, 1'b0);
        check("none addr0", obs_addr[0], 32'h1028);
        check("none addr2", obs_addr[2], 32'h1030);
        check("none addr3", obs_addr[3], 32'h1048);
        check("none addr5", obs_addr[5], 32'h1050);

        set_cmd(32'h1000, 8, 10, 20, 2, 1, 3, 2, 1);
        walk("mirror h", 0, 1'b0);
        check("h row0", {obs_addr[0], obs_addr[1], obs_addr[2]}, {32'h1030, 32'h102C, 32'h1028});

        set_cmd(32'h1000, 8, 10, 20, 2, 1, 3, 2, 2);
        walk("mirror v", 0, 1'b0);
        check("v row0/row1", {obs_addr[0], obs_addr[2], obs_addr[3]}, {32'h1048, 32'h1050, 32'h1028});

        set_cmd(32'h1000, 8, 10, 20, 2, 1, 3, 2, 3);
        walk("mirror hv", 0, 1'b0);
        check("hv ends", {obs_addr[0], obs_addr[5]}, {32'h1050, 32'h1028});

        set_cmd(32'h1000, 8, 10, 20, 2, 1, 3, 2, 0);
        walk("backpressure", 2, 1'b0);
        walk("start while busy", 0, 1'b1);

        set_cmd(32'h1000, 8, 10, 20, 2, 1, 0, 2, 0);
        walk("clipw zero", 0, 1'b0);
        set_cmd(32'h1000, 8, 10, 20, 2, 1, 3, 2, 5);
        walk("mode 5", 0, 1'b0);
        set_cmd(32'h2000, 16, 7, 9, 4, 3, 1, 1, 3);
        walk("1x1", 0, 1'b0);
        check("1x1 addr", obs_addr[0], 32'h20D0);

        set_cmd(32'h1000, 8, 10, 20, 2, 1, 3, 2, 0);
        bif.ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("beat3 before reset", {bif.valid, bif.src_addr}, {1'b1, 32'h1030});
        rst = 1'b1;
        @(negedge clk);
        check("after mid-walk reset", {bif.valid, busy, done, bif.last, bif.src_addr}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", {bif.valid, busy, done}, 3'b000);

        for (int i = 0; i < 10; i++) begin
            set_cmd($urandom, $urandom_range(1, 100), $urandom_range(0, 65535), $urandom_range(0, 65535),
                    $urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(1, 7),
                    $urandom_range(1, 4), $urandom_range(0, 3));
            walk("random", 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/painterengine_gpu_blit_walker.md
Name: painterengine_gpu_blit_walker

Overview:
- Consumes the clip result of the GPU clip stage (destination x/y plus clipped source rectangle) and walks it pixel by pixel.
- Emits one beat per pixel, carrying the source texture byte address and the destination coordinate, over a valid/ready stream into the texel fetch/blend path.
- Applies the texture mirror mode to the source traversal order.

Parameters:
- PARAM_TEXTURE_MAX_SIZE, 16, width of all coordinate/size fields.
- PARAM_ADDRESS_WIDTH, 32, width of texture byte addresses.

Ports:
- i_wire_clock  in  1  clock.
- i_wire_reset  in  1  synchronous active-high reset.
- i_wire_start  in  1  start pulse; sampled only in IDLE or DONE.
- i_wire_texture_base  in  PARAM_ADDRESS_WIDTH  source texture byte base.
- i_wire_texture_width  in  PARAM_TEXTURE_MAX_SIZE  source texture width in pixels (row stride).
- i_wire_x, i_wire_y  in  PARAM_TEXTURE_MAX_SIZE each  destination origin of clipped rect.
- i_wire_clipx, i_wire_clipy, i_wire_clipw, i_wire_cliph  in  PARAM_TEXTURE_MAX_SIZE each  clipped source rect.
- i_wire_mirror_mode  in  3  0 none, 1 H, 2 V, 3 HV.
- o_wire_valid  out  1  beat valid.
- i_wire_ready  in  1  downstream accepts beat.
- o_wire_src_addr  out  PARAM_ADDRESS_WIDTH  source texel byte address.
- o_wire_dst_x, o_wire_dst_y  out  PARAM_TEXTURE_MAX_SIZE each  destination pixel.
- o_wire_last  out  1  final beat of rect.
- o_wire_busy  out  1  high in SETUP/EMIT.
- o_wire_done  out  1  high in DONE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: IDLE; valid, last, busy and done = 0; src_addr, dst_x, dst_y = 0.
- Reset asserted mid-walk aborts immediately. No further beats; the next cycle is IDLE.
- States: IDLE -> SETUP -> EMIT -> DONE.
  - IDLE/DONE with start=1: latch all inputs, go to SETUP. Start in SETUP/EMIT is ignored.
  - SETUP (1 cycle): if clipw==0, cliph==0 or mirror_mode>3, go to DONE with zero beats. Otherwise load the counters, compute the first beat, go to EMIT.
  - EMIT: valid=1. A beat transfers when valid&&ready.
    - With ready=0, every output holds stable.
    - Column counter c runs 0..clipw-1; row counter r runs 0..cliph-1. c advances per transfer; at c==clipw-1, c wraps to 0 and r increments.
    - The transfer with c==clipw-1 && r==cliph-1 carries last=1 and moves to DONE; valid=0 in the next cycle.
  - DONE: done=1, held until the next start.
- Latency: start sampled at edge N, first valid beat at edge N+2. With ready held high, the walk finishes one beat per cycle.
- Per beat:
  - dst_x = x+c, dst_y = y+r. Mod 2^PARAM_TEXTURE_MAX_SIZE.
  - src_col = clipx+c, or clipx+clipw-1-c if H or HV.
  - src_row = clipy+r, or clipy+cliph-1-r if V or HV.
  - src_addr = base + (src_row*texture_width + src_col)*4, mod 2^PARAM_ADDRESS_WIDTH.
- Arithmetic: coordinate/size inputs are unsigned. Any implementation is allowed (incremental step ±4 / ±stride*4, or a multiply in SETUP) as long as outputs match the formula bit-exactly.
- No throughput bubbles: one transfer per cycle when ready=1, including across row wrap.
- A 1x1 rect produces a single beat with last=1.
- A start pulse arriving together with the DONE entry cycle is not sampled; start is sampled only while already in IDLE/DONE.

Test Plan:
- Mode NONE: base=0x1000, width=8, clip (2,1,3,2), x=10, y=20, ready=1.
  - Addrs: 0x1028, 0x102C, 0x1030, 0x1048, 0x104C, 0x1050.
  - dst: (10,20) (11,20) (12,20) (10,21) (11,21) (12,21).
  - last only on beat 6; first valid 2 cycles after start; done 1 cycle after beat 6.
- Same rect, each mirror mode, first-row addresses:
  - Mode H: 0x1030, 0x102C, 0x1028.
  - Mode V: 0x1048, 0x104C, 0x1050 (second row 0x1028...).
  - Mode HV: first beat 0x1050, last beat 0x1028.
  - dst sequences are identical to NONE in all three modes.
- Backpressure: NONE case with ready low for 3 cycles at beat 2.
  - Addr 0x102C and dst (11,20) stay stable with valid=1.
  - Walk resumes without skipping or duplicating beats; 6 transfers total.
- Degenerate inputs:
  - clipw=0 -> no valid ever, done 2 cycles after start.
  - mirror_mode=5 -> same.
  - 1x1 rect -> single beat with last=1.
- Start while busy is ignored (the walk completes with the original 6 beats).
- Reset mid-walk: reset=1 at beat 3 -> valid=0 next cycle, IDLE, busy=0.
- Restart from DONE: a new start in DONE begins a fresh walk.
